// File: rtl/kronos_imem.sv
// -----------------------------------------------------------------------------
// kronos_imem
//
// Instruction memory responder for the Kronos fetch bus. It is a word-wide
// synchronous array with a configurable number of wait states between address
// accept and data grant. With WAIT_STATES=0 it sustains one word per cycle for
// back-to-back fetches. A side write port loads the program independently of
// the fetch FSM.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   BASE_ADDR    byte address of word 0
//   WAIT_STATES  extra cycles between accept and data (0..15)
//
// Ports:
//   clk         clock
//   rstz        asynchronous active-low reset
//   instr_addr  fetch byte address, sampled on accept
//   instr_req   fetch side can take a word this cycle
//   instr_gnt   instr_data valid and transferred this cycle
//   instr_data  read word
//   instr_err   fetch error, qualified by instr_gnt
//   prog_we     program write strobe
//   prog_addr   program word index
//   prog_data   program write data
//
// Optional feature (macro KRONOS_IMEM_ERR_EN):
//   When defined, a misaligned or out-of-range latched address returns
//   instr_err=1 and instr_data=0 with the grant, and the array is not read.
//   When undefined, instr_err is tied low and addresses alias modulo DEPTH.
// -----------------------------------------------------------------------------
module kronos_imem #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic [31:0]   instr_addr,
  input  logic          instr_req,
  output logic          instr_gnt,
  output logic [31:0]   instr_data,
  output logic          instr_err,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [31:0]   mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic [31:0]   addr_q,  addr_d;
  logic [31:0]   data_q,  data_d;
  logic          err_q,   err_d;

  logic          gnt;
  logic          accept;
  logic          rd_en;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_off;
  logic [AW-1:0] rd_idx;
  logic          rd_bad;

  // In RESP the grant simply follows the request: the held word is handed
  // over the first cycle the fetch side can take it.
  assign gnt    = (state_q == ST_RESP) && instr_req;

  // A new address is taken from IDLE, or in the same cycle a word is granted.
  assign accept = ((state_q == ST_IDLE) && instr_req) || gnt;

  // With no wait states the array is read on the accept edge using the live
  // address; otherwise it is read on the last WAIT cycle from the latched one.
  assign rd_en   = (WAIT_STATES == 0) ? accept
                                      : ((state_q == ST_WAIT) && (cnt_q == 4'd1));
  assign rd_addr = accept ? instr_addr : addr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_idx  = rd_off[AW+1:2];

`ifdef KRONOS_IMEM_ERR_EN
  // Offsets below BASE_ADDR wrap to large values and land out of range.
  assign rd_bad    = (|rd_off[1:0]) || (|rd_off[31:AW+2]);
  assign instr_err = gnt && err_q;
`else
  logic unused_rd_bits;
  assign rd_bad         = 1'b0;
  assign instr_err      = 1'b0;
  assign unused_rd_bits = ^{rd_off[31:AW+2], rd_off[1:0], err_q};
`endif

  assign instr_gnt  = gnt;
  assign instr_data = data_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;

    if (accept) begin
      addr_d = instr_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (instr_req) begin
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          cnt_d   = WS;
        end
      end
      ST_WAIT: begin
        // Counts WAIT_STATES down to 1; the count-1 cycle performs the read.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // With req low nothing changes: word and latched address are held.
        if (gnt && (WAIT_STATES != 0)) begin
          state_d = ST_WAIT;
          cnt_d   = WS;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (rd_en) begin
      err_d  = rd_bad;
      data_d = rd_bad ? 32'h0 : mem[rd_idx];
    end
  end

  // NOTE: the array has no reset; its contents are undefined until written
  // through the program port, which keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values; this also gives the array read-before-write behaviour.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_kronos_imem.sv
// -----------------------------------------------------------------------------
// tb_kronos_imem
//
// Two instances: u_ws0 (WAIT_STATES=0, BASE 0) and u_ws2 (WAIT_STATES=2,
// BASE 0x1000), both DEPTH=16. A directed table plus hand-written sequences
// cover reset, pipelined fetch, held words, read-before-write, wait states,
// the error/alias boundary and mid-operation reset; a randomized phase is
// checked against a protocol-level reference model.
// -----------------------------------------------------------------------------
module tb_kronos_imem;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstz;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        gnt   [2];
  logic [31:0] data  [2];
  logic        err   [2];
  logic        we    [2];
  logic [3:0]  paddr [2];
  logic [31:0] pdata [2];

  int          ws_of   [2] = '{0, 2};
  logic [31:0] base_of [2] = '{32'h0, 32'h1000};

  logic [31:0] model_mem [2][DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kronos_imem #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rstz(rstz),
    .instr_addr(addr[0]), .instr_req(req[0]), .instr_gnt(gnt[0]),
    .instr_data(data[0]), .instr_err(err[0]),
    .prog_we(we[0]), .prog_addr(paddr[0]), .prog_data(pdata[0])
  );

  kronos_imem #(.DEPTH(DEPTH), .BASE_ADDR(32'h1000), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rstz(rstz),
    .instr_addr(addr[1]), .instr_req(req[1]), .instr_gnt(gnt[1]),
    .instr_data(data[1]), .instr_err(err[1]),
    .prog_we(we[1]), .prog_addr(paddr[1]), .prog_data(pdata[1])
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        exp_gnt;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {err, data} for a fetch of byte address a on instance d.
  function automatic logic [32:0] model_fetch(input int d, input logic [31:0] a);
    logic [31:0] off;
    int unsigned word;
    off  = a - base_of[d];
    word = off / 4;
`ifdef KRONOS_IMEM_ERR_EN
    if ((off % 4) != 0 || word >= DEPTH) return {1'b1, 32'h0};
`endif
    return {1'b0, model_mem[d][word % DEPTH]};
  endfunction

  logic [32:0] exp_fe;
  logic [31:0] old_w2;
  bit          pend    [2];
  int          acc_cyc [2];
  logic [31:0] acc_addr[2];
  int          cyc;
  bit          exp_g;

  initial begin
    rstz = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = 32'h0; we[d] = 1'b0; paddr[d] = 4'h0; pdata[d] = 32'h0;
    end

    // ---- reset held low for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_gnt%0d", d), {31'b0, gnt[d]}, 32'h0);
      check($sformatf("reset_data%0d", d), data[d], 32'h0);
      check($sformatf("reset_err%0d", d), {31'b0, err[d]}, 32'h0);
    end
    tick();
    rstz = 1'b1;

    // ---- program load through the write port
    for (int k = 0; k < DEPTH; k++) begin
      for (int d = 0; d < 2; d++) begin
        we[d] = 1'b1; paddr[d] = 4'(k); pdata[d] = $urandom;
        model_mem[d][k] = pdata[d];
      end
      tick();
    end
    for (int d = 0; d < 2; d++) we[d] = 1'b0;

    // ---- directed table on the zero-wait instance
    vecs[0] = '{1'b1, 32'h00, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h04, 1'b1, model_mem[0][0]};
    vecs[2] = '{1'b1, 32'h08, 1'b1, model_mem[0][1]};
    vecs[3] = '{1'b0, 32'h0C, 1'b0, model_mem[0][2]};
    vecs[4] = '{1'b0, 32'h00, 1'b0, model_mem[0][2]};
    vecs[5] = '{1'b0, 32'h00, 1'b0, model_mem[0][2]};
    vecs[6] = '{1'b0, 32'h00, 1'b0, model_mem[0][2]};
    vecs[7] = '{1'b1, 32'h14, 1'b1, model_mem[0][2]};
    vecs[8] = '{1'b1, 32'h00, 1'b1, model_mem[0][5]};
    vecs[9] = '{1'b0, 32'h00, 1'b0, model_mem[0][0]};
    for (int i = 0; i < 10; i++) begin
      req[0] = vecs[i].req; addr[0] = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), {31'b0, gnt[0]}, {31'b0, vecs[i].exp_gnt});
      check($sformatf("vec%0d_data", i), data[0], vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), {31'b0, err[0]}, 32'h0);
      tick();
    end

    // ---- read-before-write on word 2
    old_w2 = model_mem[0][2];
    req[0] = 1'b1; addr[0] = 32'h08;
    we[0] = 1'b1; paddr[0] = 4'd2; pdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    check("rbw_gnt_k", {31'b0, gnt[0]}, 32'h1);
    check("rbw_data_k", data[0], model_mem[0][0]);
    tick();
    we[0] = 1'b0;
    model_mem[0][2] = 32'hDEADBEEF;
    @(negedge clk);
    check("rbw_old_gnt", {31'b0, gnt[0]}, 32'h1);
    check("rbw_old_data", data[0], old_w2);
    tick();
    addr[0] = 32'h00;
    @(negedge clk);
    check("rbw_new_data", data[0], 32'hDEADBEEF);
    tick();

    // ---- misaligned / out-of-range fetch (alias when the feature is off)
    addr[0] = 32'h02;
    @(negedge clk);
    check("bnd_pre_data", data[0], model_mem[0][0]);
    tick();
    addr[0] = 32'h0 + 4 * DEPTH;
    exp_fe  = model_fetch(0, 32'h02);
    @(negedge clk);
    check("bnd_mis_gnt", {31'b0, gnt[0]}, 32'h1);
    check("bnd_mis_err", {31'b0, err[0]}, {31'b0, exp_fe[32]});
    check("bnd_mis_data", data[0], exp_fe[31:0]);
    tick();
    addr[0] = 32'h00;
    exp_fe  = model_fetch(0, 32'h0 + 4 * DEPTH);
    @(negedge clk);
    check("bnd_oor_gnt", {31'b0, gnt[0]}, 32'h1);
    check("bnd_oor_err", {31'b0, err[0]}, {31'b0, exp_fe[32]});
    check("bnd_oor_data", data[0], exp_fe[31:0]);
    tick();
    req[0] = 1'b0;

    // ---- two wait states: single request at word 4
    req[1] = 1'b1; addr[1] = 32'h1010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("ws2_gnt_c%0d", c), {31'b0, gnt[1]}, 32'h0);
      tick();
    end
    @(negedge clk);
    check("ws2_gnt_c3", {31'b0, gnt[1]}, 32'h1);
    check("ws2_data_c3", data[1], model_mem[1][4]);
    tick();
    req[1] = 1'b0;

    // ---- asynchronous reset mid-operation discards the pending word
    req[0] = 1'b1; addr[0] = 32'h04;
    #2;
    rstz = 1'b0;
    #1;
    check("mid_rst_gnt0", {31'b0, gnt[0]}, 32'h0);
    check("mid_rst_data0", data[0], 32'h0);
    check("mid_rst_data1", data[1], 32'h0);
    tick();
    rstz = 1'b1;
    req[0] = 1'b0;

    // ---- randomized fetch against the protocol model
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0; acc_cyc[d] = 0; acc_addr[d] = 32'h0;
    end
    cyc = 0;
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        req[d] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) addr[d] = $urandom;
        else addr[d] = base_of[d] + 32'(4 * $urandom_range(0, DEPTH - 1));
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        // A word becomes available WAIT_STATES+1 cycles after its accept and
        // is handed over the first such cycle the request is high.
        exp_g = pend[d] && (cyc - acc_cyc[d] >= ws_of[d] + 1) && req[d];
        check($sformatf("rand_gnt%0d", d), {31'b0, gnt[d]}, {31'b0, exp_g});
        if (exp_g) begin
          exp_fe = model_fetch(d, acc_addr[d]);
          check($sformatf("rand_data%0d", d), data[d], exp_fe[31:0]);
          check($sformatf("rand_err%0d", d), {31'b0, err[d]}, {31'b0, exp_fe[32]});
        end
        if (req[d] && (!pend[d] || exp_g)) begin
          pend[d] = 1'b1; acc_cyc[d] = cyc; acc_addr[d] = addr[d];
        end
      end
      cyc++;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
